// File: rtl/pipeline_4_writeback_pkg.sv
// Shared definitions for the write-back stage: control-word field positions,
// write-back source encodings, the HALT type bit and redirect FSM states.
package pipeline_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CTL_W     = 22;
  localparam int unsigned INST_W    = 6;
  localparam int unsigned WNUM_W    = 3;
  localparam int unsigned LINK_W    = 9;

  localparam int unsigned CTL_WNUM  = 0;
  localparam int unsigned CTL_WRITE = 3;
  localparam int unsigned CTL_WBSEL = 4;
  localparam int unsigned CTL_LOADS = 8;
  localparam int unsigned CTL_LINK  = 9;

  localparam int unsigned INST_HALT = 5;

  typedef enum logic [1:0] {
    WB_RESULT = 2'b00,
    WB_MDATA  = 2'b01,
    WB_LINK   = 2'b10,
    WB_ZERO   = 2'b11
  } wb_sel_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_FLUSH = 1'b1
  } rd_state_e;

  // Register-file write port as seen by the execute-stage bypass.
  typedef struct packed {
    logic              valid;
    logic [WNUM_W-1:0] num;
    logic [DATA_W-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/wb_redirect_ctrl.sv
// Taken-branch redirect: one-cycle pc_load with registered target, followed by
// an upstream flush window of FLUSH_CYCLES cycles. i_halt forces the idle state.
module wb_redirect_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_W         = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_branch,
  input  logic [PC_W-1:0] i_target,
  input  logic            i_halt,
  output logic [PC_W-1:0] o_pc_target,
  output logic            o_pc_load,
  output logic            o_flush
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  rd_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [PC_W-1:0]  r_target, w_target_nxt;
  logic             r_pc_load, w_pc_load_nxt;
  logic             r_flush, w_flush_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RD_IDLE;
      r_cnt     <= '0;
      r_target  <= '0;
      r_pc_load <= 1'b0;
      r_flush   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_target  <= w_target_nxt;
      r_pc_load <= w_pc_load_nxt;
      r_flush   <= w_flush_nxt;
    end
  end

  // Branches seen while flushing belong to killed instructions and are dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_target_nxt  = r_target;
    w_pc_load_nxt = 1'b0;
    w_flush_nxt   = 1'b0;
    if (i_halt) begin
      w_state_nxt = RD_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (i_branch) begin
            w_state_nxt   = RD_FLUSH;
            w_cnt_nxt     = CNT_W'(FLUSH_CYCLES);
            w_target_nxt  = i_target;
            w_pc_load_nxt = 1'b1;
            w_flush_nxt   = 1'b1;
          end
        end
        RD_FLUSH: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = RD_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            w_flush_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = RD_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_pc_target = r_target;
  assign o_pc_load   = r_pc_load;
  assign o_flush     = r_flush;

endmodule

// File: rtl/pipeline_4_writeback.sv
// Pipeline stage 4: write-back select, status register, branch redirect and HALT.
// Define WB_FORWARD_EN to add the execute-stage bypass ports (fwd_*, fwd2_*).
module pipeline_4_writeback
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_W         = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTL_W-1:0]  control_in,
  input  logic [INST_W-1:0] inst_type_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] mdata,
  input  logic              N_in,
  input  logic              Z_in,
  input  logic              V_in,
  input  logic              do_delayed_B_in,
  input  logic [DATA_W-1:0] delayed_B_in,
  output logic [DATA_W-1:0] w_data,
  output logic [WNUM_W-1:0] w_num,
  output logic              w_en,
  output logic [2:0]        status,
  output logic [PC_W-1:0]   pc_target,
  output logic              pc_load,
  output logic              flush_out,
  output logic              halted
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [WNUM_W-1:0] fwd_num,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd2_valid,
  output logic [WNUM_W-1:0] fwd2_num,
  output logic [DATA_W-1:0] fwd2_data
`endif
);

  logic [WNUM_W-1:0] r_wnum;
  logic              r_write;
  wb_sel_e           r_wbsel;
  logic              r_loads;
  logic [LINK_W-1:0] r_link;
  logic              r_halt;
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_nzv;
  logic [2:0]        r_status;
  logic              r_halted;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_unused_bits;

  assign w_unused_bits = ^{control_in[7:6], control_in[21:18], inst_type_in[4:0],
                           delayed_B_in[DATA_W-1:PC_W]};

  // Control fields reset to a bubble; datapath values do not need a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wnum  <= '0;
      r_write <= 1'b0;
      r_wbsel <= WB_RESULT;
      r_loads <= 1'b0;
      r_link  <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_wnum  <= control_in[CTL_WNUM +: WNUM_W];
      r_write <= control_in[CTL_WRITE];
      r_wbsel <= wb_sel_e'(control_in[CTL_WBSEL +: 2]);
      r_loads <= control_in[CTL_LOADS];
      r_link  <= control_in[CTL_LINK +: LINK_W];
      r_halt  <= inst_type_in[INST_HALT];
    end
  end

  always_ff @(posedge clk) begin
    r_result <= result_in;
    r_nzv    <= {N_in, Z_in, V_in};
  end

  // Status and halt are frozen once halted; the HALT instruction itself still retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= 3'b000;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (r_loads) r_status <= r_nzv;
      if (r_halt)  r_halted <= 1'b1;
    end
  end

  always_comb begin
    w_wb_data = '0;
    case (r_wbsel)
      WB_RESULT: w_wb_data = r_result;
      WB_MDATA:  w_wb_data = mdata;
      WB_LINK:   w_wb_data = DATA_W'(r_link);
      WB_ZERO:   w_wb_data = '0;
      default:   w_wb_data = '0;
    endcase
  end

  assign w_data = w_wb_data;
  assign w_num  = r_wnum;
  assign w_en   = r_write & ~r_halted;
  assign status = r_status;
  assign halted = r_halted;

  wb_redirect_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .PC_W         (PC_W)
  ) u_redirect (
    .clk         (clk),
    .rst         (rst),
    .i_branch    (do_delayed_B_in),
    .i_target    (delayed_B_in[PC_W-1:0]),
    .i_halt      (r_halted | r_halt),
    .o_pc_target (pc_target),
    .o_pc_load   (pc_load),
    .o_flush     (flush_out)
  );

`ifdef WB_FORWARD_EN
  wb_port_t r_fwd2;

  always_ff @(posedge clk) begin
    if (rst) r_fwd2 <= '0;
    else     r_fwd2 <= '{valid: w_en, num: w_num, data: w_wb_data};
  end

  assign fwd_valid  = w_en;
  assign fwd_num    = w_num;
  assign fwd_data   = w_wb_data;
  assign fwd2_valid = r_fwd2.valid;
  assign fwd2_num   = r_fwd2.num;
  assign fwd2_data  = r_fwd2.data;
`endif

endmodule

// File: tb/tb_pipeline_4_writeback.sv
// Scoreboard bench for pipeline_4_writeback: stimulus queues expected writes,
// redirects and flush-window lengths; a negedge monitor pops and compares them.
module tb_pipeline_4_writeback;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned PC_W         = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] control_in;
  logic [5:0]  inst_type_in;
  logic [15:0] result_in;
  logic [15:0] mdata;
  logic        N_in, Z_in, V_in;
  logic        do_delayed_B_in;
  logic [15:0] delayed_B_in;
  logic [15:0] w_data;
  logic [2:0]  w_num;
  logic        w_en;
  logic [2:0]  status;
  logic [PC_W-1:0] pc_target;
  logic        pc_load;
  logic        flush_out;
  logic        halted;
`ifdef WB_FORWARD_EN
  logic        fwd_valid, fwd2_valid;
  logic [2:0]  fwd_num, fwd2_num;
  logic [15:0] fwd_data, fwd2_data;
`endif

  int checks = 0;
  int errors = 0;

  logic [18:0]     exp_wr[$];
  logic [PC_W-1:0] exp_rd[$];
  int              exp_fl[$];
  int              fl_run = 0;

  localparam logic [21:0] BUB = 22'd0;

  always #5 clk = ~clk;

  pipeline_4_writeback #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .PC_W         (PC_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .control_in      (control_in),
    .inst_type_in    (inst_type_in),
    .result_in       (result_in),
    .mdata           (mdata),
    .N_in            (N_in),
    .Z_in            (Z_in),
    .V_in            (V_in),
    .do_delayed_B_in (do_delayed_B_in),
    .delayed_B_in    (delayed_B_in),
    .w_data          (w_data),
    .w_num           (w_num),
    .w_en            (w_en),
    .status          (status),
    .pc_target       (pc_target),
    .pc_load         (pc_load),
    .flush_out       (flush_out),
    .halted          (halted)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid       (fwd_valid),
    .fwd_num         (fwd_num),
    .fwd_data        (fwd_data),
    .fwd2_valid      (fwd2_valid),
    .fwd2_num        (fwd2_num),
    .fwd2_data       (fwd2_data)
`endif
  );

  function automatic logic [21:0] mk_ctl(input logic [2:0] wnum, input logic wr,
                                         input logic [1:0] sel, input logic ld,
                                         input logic [8:0] link);
    logic [21:0] c;
    c        = '0;
    c[2:0]   = wnum;
    c[3]     = wr;
    c[5:4]   = sel;
    c[8]     = ld;
    c[17:9]  = link;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One pipeline cycle: md is the RAM data for the instruction now in stage 4.
  task automatic step(input logic [21:0] ctl, input logic [5:0] it, input logic [15:0] res,
                      input logic [2:0] nzv, input logic br, input logic [15:0] tgt,
                      input logic [15:0] md);
    control_in      = ctl;
    inst_type_in    = it;
    result_in       = res;
    {N_in, Z_in, V_in} = nzv;
    do_delayed_B_in = br;
    delayed_B_in    = tgt;
    mdata           = md;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    step(BUB, 6'd0, 16'h0000, 3'b000, 1'b0, 16'h0000, 16'h0000);
  endtask

  always @(negedge clk) begin : monitor
    logic [18:0]     ew;
    logic [PC_W-1:0] er;
    int              ef;
    if (w_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual num=%0d data=%0h required none", w_num, w_data);
      end else begin
        ew = exp_wr.pop_front();
        if ({w_num, w_data} !== ew) begin
          errors++;
          $display("FAIL write actual num=%0d data=%0h required num=%0d data=%0h",
                   w_num, w_data, ew[18:16], ew[15:0]);
        end
      end
    end
    if (pc_load) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pc_load actual target=%0h required none", pc_target);
      end else begin
        er = exp_rd.pop_front();
        if (pc_target !== er) begin
          errors++;
          $display("FAIL pc_target actual=%0h required=%0h", pc_target, er);
        end
      end
    end
    if (flush_out) begin
      fl_run++;
    end else if (fl_run > 0) begin
      checks++;
      if (exp_fl.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flush actual len=%0d required none", fl_run);
      end else begin
        ef = exp_fl.pop_front();
        if (fl_run != ef) begin
          errors++;
          $display("FAIL flush_len actual=%0d required=%0d", fl_run, ef);
        end
      end
      fl_run = 0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bubble();
    bubble();
    rst = 1'b0;
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_flush", 32'(flush_out), 32'd0);
    chk("rst_pc_target", 32'(pc_target), 32'd0);

    // Load from RAM, ALU result, link PC and the zero source.
    exp_wr.push_back({3'd3, 16'hBEEF});
    step(mk_ctl(3'd3, 1'b1, 2'b01, 1'b0, 9'd0), 6'd0, 16'h1111, 3'b000, 1'b0, 16'h0, 16'h0);
    step(BUB, 6'd0, 16'h0000, 3'b000, 1'b0, 16'h0, 16'hBEEF);
    exp_wr.push_back({3'd1, 16'h1234});
    step(mk_ctl(3'd1, 1'b1, 2'b00, 1'b0, 9'd0), 6'd0, 16'h1234, 3'b000, 1'b0, 16'h0, 16'h0);
    exp_wr.push_back({3'd6, 16'h01A5});
    step(mk_ctl(3'd6, 1'b1, 2'b10, 1'b0, 9'h1A5), 6'd0, 16'h2222, 3'b000, 1'b0, 16'h0, 16'h0);
    exp_wr.push_back({3'd2, 16'h0000});
    step(mk_ctl(3'd2, 1'b1, 2'b11, 1'b0, 9'd0), 6'd0, 16'hFFFF, 3'b000, 1'b0, 16'h0, 16'h0);
    bubble();

    // Flags load alongside a register write, then a non-loading instruction.
    exp_wr.push_back({3'd4, 16'h0042});
    step(mk_ctl(3'd4, 1'b1, 2'b00, 1'b1, 9'd0), 6'd0, 16'h0042, 3'b101, 1'b0, 16'h0, 16'h0);
    chk("status_before_load", 32'(status), 32'd0);
    step(mk_ctl(3'd0, 1'b0, 2'b00, 1'b0, 9'd0), 6'd0, 16'h0000, 3'b010, 1'b0, 16'h0, 16'h0);
    chk("status_loaded", 32'(status), 32'h5);
    bubble();
    chk("status_held", 32'(status), 32'h5);

    // Redirect with a second branch pulse while flushing.
    exp_rd.push_back(9'h123);
    exp_fl.push_back(2);
    step(BUB, 6'd0, 16'h0, 3'b000, 1'b1, 16'h0123, 16'h0);
    step(BUB, 6'd0, 16'h0, 3'b000, 1'b1, 16'h0055, 16'h0);
    bubble();
    bubble();
    bubble();

    // Reset during the first flush cycle.
    exp_rd.push_back(9'h0AA);
    exp_fl.push_back(1);
    step(BUB, 6'd0, 16'h0, 3'b000, 1'b1, 16'h00AA, 16'h0);
    rst = 1'b1;
    bubble();
    rst = 1'b0;
    chk("rstmid_flush", 32'(flush_out), 32'd0);
    chk("rstmid_pc_load", 32'(pc_load), 32'd0);
    chk("rstmid_status", 32'(status), 32'd0);
    chk("rstmid_w_en", 32'(w_en), 32'd0);
    bubble();

    // HALT retires its own write; a branch in the same cycle is suppressed.
    exp_wr.push_back({3'd7, 16'h0777});
    step(mk_ctl(3'd7, 1'b1, 2'b00, 1'b0, 9'd0), 6'h20, 16'h0777, 3'b000, 1'b0, 16'h0, 16'h0);
    chk("halted_not_yet", 32'(halted), 32'd0);
    step(mk_ctl(3'd5, 1'b1, 2'b00, 1'b1, 9'd0), 6'd0, 16'h5555, 3'b111, 1'b1, 16'h0077, 16'h0);
    chk("halted_set", 32'(halted), 32'd1);
    chk("halt_w_en", 32'(w_en), 32'd0);
    step(BUB, 6'd0, 16'h0, 3'b000, 1'b1, 16'h0088, 16'h0);
    chk("halt_pc_load", 32'(pc_load), 32'd0);
    chk("halt_flush", 32'(flush_out), 32'd0);
    chk("halt_status_frozen", 32'(status), 32'd0);
    bubble();
    rst = 1'b1;
    bubble();
    rst = 1'b0;
    chk("halted_cleared", 32'(halted), 32'd0);

    // Back-to-back writes r1=5 then r2=9.
    exp_wr.push_back({3'd1, 16'h0005});
    step(mk_ctl(3'd1, 1'b1, 2'b00, 1'b0, 9'd0), 6'd0, 16'h0005, 3'b000, 1'b0, 16'h0, 16'h0);
    exp_wr.push_back({3'd2, 16'h0009});
    step(mk_ctl(3'd2, 1'b1, 2'b00, 1'b0, 9'd0), 6'd0, 16'h0009, 3'b000, 1'b0, 16'h0, 16'h0);
`ifdef WB_FORWARD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'd1);
    chk("fwd_num", 32'(fwd_num), 32'd2);
    chk("fwd_data", 32'(fwd_data), 32'h9);
    chk("fwd2_valid", 32'(fwd2_valid), 32'd1);
    chk("fwd2_num", 32'(fwd2_num), 32'd1);
    chk("fwd2_data", 32'(fwd2_data), 32'h5);
`endif
    bubble();
    bubble();
    bubble();

    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
    chk("pending_redirects", 32'(exp_rd.size()), 32'd0);
    chk("pending_flushes", 32'(exp_fl.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_4_writeback.md
Name: pipeline_4_writeback

Overview:
Final stage of the 16-bit pipeline, directly downstream of the memory-write stage. It registers that stage's result, control word, instruction type and flags, and selects the write-back value from ALU result, RAM read data or link PC. It drives the register-file write port, holds the architectural N/Z/V status register, converts a taken delayed branch into a PC redirect plus an upstream flush window, and latches HALT.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_out stays high after a redirect (1..7)
PC_W, 9, PC / RAM address width

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous active-high reset
control_in  in  22  control word from stage 3 (control_out)
inst_type_in  in  6  instruction type from stage 3
result_in  in  16  ALU/address result from stage 3
mdata  in  16  RAM read data (valid the cycle after addr_mem was presented)
N_in  in  1  stage-3 N_out
Z_in  in  1  stage-3 Z_out
V_in  in  1  stage-3 V_out
do_delayed_B_in  in  1  stage-3 branch-taken decision
delayed_B_in  in  16  stage-3 branch target (low PC_W bits used)
w_data  out  16  register-file write data
w_num  out  3  register-file write index
w_en  out  1  register-file write enable
status  out  3  architectural {N,Z,V}
pc_target  out  PC_W  redirect target
pc_load  out  1  one-cycle PC redirect strobe
flush_out  out  1  kill younger instructions in stages 0..2
halted  out  1  sticky halt indicator

Behaviour:
- Control fields (registered word ctl): [2:0] write index, [3] reg write, [5:4] wb_sel (00 result, 01 mdata, 10 link = zero-extended ctl[17:9], 11 zero), [8] loads-flags, [17:9] link PC, rest reserved. inst_type[5] = HALT.
- Stage register: ctl, inst_type, result, N/Z/V and link captured on every clk; rst clears ctl and inst_type to 0, making a bubble. result has no reset.
- mdata is consumed unregistered in the stage-4 cycle, so load-to-writeback needs no extra latency.
- w_num = ctl[2:0]; w_data per wb_sel; w_en = ctl[3] & ~halted. All are combinational from the registered values, so a write is visible one cycle after the stage-3 output.
- status: 3-bit register, reset 3'b000, loaded with the registered {N,Z,V} on the cycle after a stage-4 instruction has ctl[8]=1. Otherwise it holds.
- Redirect FSM, states IDLE and FLUSH, with counter cnt of width clog2(FLUSH_CYCLES+1):
  - IDLE, do_delayed_B_in=1: next cycle pc_load=1 (exactly one cycle), pc_target = delayed_B_in[PC_W-1:0] (registered), cnt=FLUSH_CYCLES, state FLUSH.
  - FLUSH: flush_out=1; cnt decrements each cycle; on cnt reaching 1, return to IDLE. do_delayed_B_in is ignored in FLUSH because it comes from a killed instruction.
  - Reset or halted forces IDLE, pc_load=0, flush_out=0, cnt=0. pc_target resets to 0.
- HALT: when the stage-4 instruction has inst_type[5]=1, halted sets on the next edge and stays set until rst. That instruction's own register write still occurs. Once halted, w_en, pc_load and flush_out stay 0 and status is frozen.
- Simultaneous events:
  - A redirect and a HALT in the same cycle: HALT wins and no pc_load is issued.
  - A flags load and a reg write in the same instruction both happen.
- Reset mid-flush: the flush window is abandoned immediately on the reset edge.

Optional Feature:
WB_FORWARD_EN. When defined, three extra outputs are added: fwd_valid (=w_en), fwd_num (=w_num) and fwd_data (=w_data), for the execute-stage bypass. A second registered copy also adds fwd2_valid, fwd2_num and fwd2_data, covering the instruction one cycle older; it is cleared by rst. When not defined, these ports are absent and upstream must stall for register hazards.

Decomposition:
- Package pipeline_pkg:
  - control field bit positions (CTL_WNUM, CTL_WRITE, CTL_WBSEL, CTL_LOADS, CTL_LINK)
  - wb_sel encodings
  - the INST_HALT bit index
  - redirect FSM state typedef
- One natural sub-module: wb_redirect_ctrl, containing the FSM, counter, pc_target register and pc_load/flush_out generation.

Test Plan:
- Load: ctl with write=1, wnum=3, wb_sel=01 and mdata=16'hBEEF -> one cycle later w_en=1, w_num=3, w_data=16'hBEEF.
- Flags: result instruction with loads=1 and inputs N=1, Z=0, V=1 -> status=3'b101 one cycle after stage 4. A following instruction with loads=0 leaves it at 3'b101.
- Redirect: do_delayed_B_in=1 with delayed_B_in=16'h0123 and FLUSH_CYCLES=2 -> pc_load for 1 cycle with pc_target=9'h123, flush_out high for exactly 2 cycles. A second do_delayed_B_in pulse during FLUSH gives no new pc_load.
- HALT: HALT instruction carrying write=1 and wnum=7 -> write occurs, halted=1 next edge. A later write instruction gives w_en=0 and a later branch gives pc_load=0. After rst, halted=0.
- Reset mid-flush: assert rst during the first FLUSH cycle -> next cycle flush_out=0, pc_load=0, status=0, w_en=0.
- WB_FORWARD_EN: back-to-back writes r1=5 then r2=9 -> fwd_num/fwd_data=2/9 and fwd2_num/fwd2_data=1/5 in the same cycle.
